// File: rtl/kernel_window_gen.sv
// rtl/kernel_window_gen.sv - KxK sliding window generator over a raster RGB stream; optional macro KWIN_EMIT_ALL_EN adds left-zero-padded edge windows
module kernel_window_gen #(
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [95:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [95:0] window_out [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0],
  output logic        window_valid,
  input  logic        window_ready,
  output logic        frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  // Previous lines; index 0 holds the most recent line. Not reset: row_cnt gates their use.
  logic [95:0]   line_buf [K-2:0][IMG_WIDTH-1:0];
  logic [95:0]   new_col  [K-1:0];
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          row_ok;
  logic          emit;

  assign pix_ready = !window_valid || window_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col_cnt == COL_LAST);
  assign row_last  = (row_cnt == ROW_LAST);
  assign row_ok    = (row_cnt >= RW'(K - 1));

`ifdef KWIN_EMIT_ALL_EN
  // Every column of a full-height row produces a window; missing left columns are zero padded.
  assign emit = row_ok;
`else
  logic col_ok;
  assign col_ok = (col_cnt >= CW'(K - 1));
  // Only windows lying entirely inside one line are produced.
  assign emit = row_ok && col_ok;
`endif

  // Incoming window column: oldest buffered line on top, live pixel at the bottom
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = line_buf[K-2-r][col_cnt];
    end
    new_col[K-1] = pix_in;
  end

  // Line buffers: each stored line moves one buffer deeper at the current column (old values read first)
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = K - 2; i > 0; i--) begin
        line_buf[i][col_cnt] <= line_buf[i-1][col_cnt];
      end
      line_buf[0][col_cnt] <= pix_in;
    end
  end

  // Window registers: shift every row left and load the new column on the right
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          window_out[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          window_out[r][c] <= window_out[r][c+1];
        end
        window_out[r][K-1] <= new_col[r];
`ifdef KWIN_EMIT_ALL_EN
        // Columns left of the line start would hold the previous line's tail; blank them.
        for (int c = 0; c < K - 1; c++) begin
          if (int'(col_cnt) + c < K - 1) begin
            window_out[r][c] <= '0;
          end
        end
`endif
      end
    end
  end

  // Raster counters, output-valid flag and end-of-frame pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        window_valid <= emit;
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end else if (window_ready) begin
        window_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_window_gen.sv
// tb/tb_kernel_window_gen.sv - scoreboard bench for kernel_window_gen; honours KWIN_EMIT_ALL_EN
module tb_kernel_window_gen;

  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WB = K * K * 96;
`ifdef KWIN_EMIT_ALL_EN
  localparam bit EMIT_ALL = 1'b1;
`else
  localparam bit EMIT_ALL = 1'b0;
`endif
  localparam int N_WIN = EMIT_ALL ? W * (H - K + 1) : (W - K + 1) * (H - K + 1);

  logic        clk = 1'b0;
  logic        reset_n;
  logic [95:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [95:0] window_out [K-1:0][K-1:0];
  logic        window_valid;
  logic        window_ready;
  logic        frame_done;

  int vectors = 0;
  int errors  = 0;
  int win_cnt;
  int fd_cnt;
  int min_r;
  logic [WB-1:0] q[$];
  logic [WB-1:0] wins[$];
  logic [95:0]   img [H][W];
  int mx, my;
  bit exp_wv, exp_fd;

  kernel_window_gen #(.KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .window_out(window_out), .window_valid(window_valid),
    .window_ready(window_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mk(int n);
    return {32'(n), 32'(-n), 32'd1};
  endfunction

  function automatic logic [31:0] rf(logic [WB-1:0] w, int r, int c);
    return w[(r*K+c)*96+64 +: 32];
  endfunction

  function automatic logic [31:0] gf(logic [WB-1:0] w, int r, int c);
    return w[(r*K+c)*96+32 +: 32];
  endfunction

  function automatic logic [95:0] ent(logic [WB-1:0] w, int r, int c);
    return w[(r*K+c)*96 +: 96];
  endfunction

  function automatic logic [WB-1:0] model_win(int x, int y);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (x - (K - 1) + c >= 0) w[(r*K+c)*96 +: 96] = img[y-(K-1)+r][x-(K-1)+c];
      end
    end
    return w;
  endfunction

  function automatic logic [WB-1:0] dut_win();
    logic [WB-1:0] w;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w[(r*K+c)*96 +: 96] = window_out[r][c];
      end
    end
    return w;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_win(string tag, logic [WB-1:0] got, logic [WB-1:0] exp);
    int bad;
    bad = 0;
    for (int i = K * K - 1; i >= 0; i--) begin
      if (got[i*96 +: 96] !== exp[i*96 +: 96]) bad = i;
    end
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s entry[%0d][%0d] got %h exp %h", tag, bad / K, bad % K,
             got[bad*96 +: 96], exp[bad*96 +: 96]);
    end
  endtask

  // Cycle model + scoreboard: check outputs, retire consumed windows, queue windows for new accepts
  always @(negedge clk) begin
    bit acc;
    bit qual;
    logic [WB-1:0] got;
    logic [95:0] e;
    if (!reset_n) begin
      mx = 0;
      my = 0;
      exp_wv = 1'b0;
      exp_fd = 1'b0;
      q.delete();
    end else begin
      chk("window_valid", 32'(window_valid), 32'(exp_wv));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("pix_ready", 32'(pix_ready), 32'(!exp_wv || window_ready));
      if (frame_done === 1'b1) fd_cnt++;
      if (window_valid === 1'b1 && window_ready === 1'b1) begin
        got = dut_win();
        vectors++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL sb_window got unexpected window exp none queued");
        end
        if (q.size() != 0) chk_win("window", got, q.pop_front());
        wins.push_back(got);
        win_cnt++;
        for (int i = 0; i < K * K; i++) begin
          e = got[i*96 +: 96];
          if (e[31:0] == 32'd1 && $signed(e[95:64]) < min_r) min_r = $signed(e[95:64]);
        end
      end
      acc = pix_valid && (!exp_wv || window_ready);
      exp_fd = 1'b0;
      if (acc) begin
        img[my][mx] = pix_in;
        qual = (my >= K - 1) && (EMIT_ALL || mx >= K - 1);
        if (qual) q.push_back(model_win(mx, my));
        exp_fd = (mx == W - 1) && (my == H - 1);
        exp_wv = qual;
        if (mx == W - 1) begin
          mx = 0;
          my = (my == H - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end else if (window_ready) begin
        exp_wv = 1'b0;
      end
    end
  end

  task automatic send(int v);
    int t;
    pix_in = mk(v);
    pix_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (pix_ready !== 1'b1 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic stream(int base, bit gap);
    for (int n = 0; n < W * H; n++) begin
      send(base + n);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic begin_test();
    win_cnt = 0;
    fd_cnt = 0;
    min_r = 32'h7fffffff;
    wins.delete();
  endtask

  task automatic check_first(string tag, int off);
`ifdef KWIN_EMIT_ALL_EN
    chk({tag, "_w0_c0"}, ent(wins[0], 1, 0)[31:0] | ent(wins[0], 1, 1)[31:0], 32'd0);
    chk({tag, "_w0_22r"}, rf(wins[0], 2, 2), 32'(off + 8));
    chk({tag, "_w1_c0"}, ent(wins[1], 0, 0)[31:0] | ent(wins[1], 2, 0)[31:0], 32'd0);
    chk({tag, "_w1_12r"}, rf(wins[1], 1, 2), 32'(off + 5));
`else
    chk({tag, "_00r"}, rf(wins[0], 0, 0), 32'(off + 0));
    chk({tag, "_02r"}, rf(wins[0], 0, 2), 32'(off + 2));
    chk({tag, "_20r"}, rf(wins[0], 2, 0), 32'(off + 8));
    chk({tag, "_22r"}, rf(wins[0], 2, 2), 32'(off + 10));
    chk({tag, "_11g"}, gf(wins[0], 1, 1), 32'(-(off + 5)));
`endif
  endtask

  initial begin
    logic [WB-1:0] held;
    reset_n = 1'b0;
    pix_valid = 1'b0;
    pix_in = '0;
    window_ready = 1'b1;
    begin_test();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_window_valid", 32'(window_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk_win("rst_window", dut_win(), '0);

    // streaming
    begin_test();
    stream(0, 1'b0);
    drain();
    chk("stream_windows", 32'(win_cnt), 32'(N_WIN));
    chk("stream_frame_done", 32'(fd_cnt), 32'd1);
    check_first("stream", 0);

    // backpressure after the first window
    begin_test();
    fork
      stream(0, 1'b0);
      begin : rdy
        int t;
        t = 0;
        while (window_valid !== 1'b1 && t < 100) begin
          @(posedge clk);
          #1;
          t++;
        end
        chk("bp_wait", 32'(t < 100), 32'd1);
        window_ready = 1'b0;
        held = dut_win();
        repeat (5) begin
          @(negedge clk);
          chk("bp_pix_ready", 32'(pix_ready), 32'd0);
          chk("bp_center_r", window_out[1][1][95:64], EMIT_ALL ? 32'd0 : 32'd5);
          chk_win("bp_frozen", dut_win(), held);
        end
        @(posedge clk);
        #1;
        window_ready = 1'b1;
      end
    join
    drain();
    chk("bp_windows", 32'(win_cnt), 32'(N_WIN));
    chk("bp_next_center_r", rf(wins[1], 1, 1), EMIT_ALL ? 32'd4 : 32'd6);

    // input gaps
    begin_test();
    stream(0, 1'b1);
    drain();
    chk("gap_windows", 32'(win_cnt), 32'(N_WIN));
    check_first("gap", 0);

    // two frames back to back
    begin_test();
    stream(0, 1'b0);
    stream(100, 1'b0);
    drain();
    chk("wrap_windows", 32'(win_cnt), 32'(2 * N_WIN));
    chk("wrap_frame_done", 32'(fd_cnt), 32'd2);
    for (int i = 0; i < N_WIN; i++) wins.pop_front();
    check_first("wrap", 100);
    min_r = 32'h7fffffff;
    foreach (wins[i]) begin
      for (int j = 0; j < K * K; j++) begin
        if (wins[i][j*96 +: 32] == 32'd1 && $signed(wins[i][j*96+64 +: 32]) < min_r)
          min_r = $signed(wins[i][j*96+64 +: 32]);
      end
    end
    chk("wrap_min_r_ge_100", 32'(min_r >= 100), 32'd1);

    // reset in the middle of a frame
    begin_test();
    for (int n = 0; n < 8; n++) send(n);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_window_valid", 32'(window_valid), 32'd0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    begin_test();
    stream(0, 1'b0);
    drain();
    chk("mid_rst_windows", 32'(win_cnt), 32'(N_WIN));
    chk("mid_rst_frame_done_cnt", 32'(fd_cnt), 32'd1);
    check_first("mid_rst", 0);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
